// File: rtl/divu_seq_pipe.sv
// Multi-cycle signed/unsigned non-restoring divider, start/busy/done handshake.
// Define DIV_ABORT_EN to add the abort input.
module divu_seq_pipe #(
  parameter int DW = 32,
  parameter int VW = 16
) (
  input  logic          clk,
  input  logic          resetn,
  input  logic          start,
  input  logic          sign,
  input  logic [DW-1:0] a,
  input  logic [VW-1:0] b,
`ifdef DIV_ABORT_EN
  input  logic          abort,
`endif
  output logic [DW-1:0] q,
  output logic [VW-1:0] r,
  output logic          dz,
  output logic          ovf,
  output logic          busy,
  output logic          done
);

  localparam int CW = $clog2(DW);

  typedef enum logic [1:0] {
    S_IDLE,
    S_CALC,
    S_FIX
  } state_t;

  state_t        r_state;
  state_t        w_nxt;
  logic [CW-1:0] r_cnt;
  logic [VW:0]   r_rem;
  logic [DW-1:0] r_quo;
  logic [VW-1:0] r_bmag;
  logic          r_nega;
  logic          r_negb;
  logic          r_bz;
  logic          r_ov;
  logic [DW-1:0] r_q;
  logic [VW-1:0] r_r;
  logic          r_dz;
  logic          r_ovf;
  logic          r_done;

  logic          w_abort;
  logic          w_busy;
  logic [DW-1:0] w_amag;
  logic [VW-1:0] w_bmag;
  logic          w_ovf_in;
  logic [VW:0]   w_shift;
  logic [VW:0]   w_step;
  logic [VW:0]   w_rfix;
  logic [VW-1:0] w_rlo;
  logic [DW-1:0] w_qfin;
  logic [VW-1:0] w_rfin;

`ifdef DIV_ABORT_EN
  assign w_abort = abort;
`else
  assign w_abort = 1'b0;
`endif

  assign w_amag   = (sign && a[DW-1]) ? -a : a;
  assign w_bmag   = (sign && b[VW-1]) ? -b : b;
  assign w_ovf_in = sign && (a == {1'b1, {(DW-1){1'b0}}}) && (&b);

  // Remainder stays within [-|b|, |b|), so VW+1 bits wrap safely.
  assign w_shift = {r_rem[VW-1:0], r_quo[DW-1]};
  assign w_step  = r_rem[VW] ? w_shift + {1'b0, r_bmag}
                             : w_shift - {1'b0, r_bmag};

  assign w_rfix = r_rem[VW] ? r_rem + {1'b0, r_bmag} : r_rem;
  assign w_rlo  = w_rfix[VW-1:0];
  assign w_rfin = r_nega ? -w_rlo : w_rlo;
  assign w_qfin = r_bz ? {DW{1'b1}}
                : ((r_nega ^ r_negb) ? -r_quo : r_quo);

  always_ff @(posedge clk) begin
    if (resetn) r_state <= S_IDLE;
    else        r_state <= w_nxt;
  end

  always_comb begin
    w_nxt = r_state;
    case (r_state)
      S_IDLE: if (start) w_nxt = S_CALC;
      S_CALC: begin
        if (w_abort)                  w_nxt = S_IDLE;
        else if (r_cnt == CW'(DW-1))  w_nxt = S_FIX;
      end
      S_FIX:   w_nxt = S_IDLE;
      default: w_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    w_busy = (r_state != S_IDLE);
  end

  always_ff @(posedge clk) begin
    if (resetn) begin
      r_cnt  <= '0;
      r_rem  <= '0;
      r_quo  <= '0;
      r_bmag <= '0;
      r_nega <= 1'b0;
      r_negb <= 1'b0;
      r_bz   <= 1'b0;
      r_ov   <= 1'b0;
      r_q    <= '0;
      r_r    <= '0;
      r_dz   <= 1'b0;
      r_ovf  <= 1'b0;
      r_done <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: if (start) begin
          r_quo  <= w_amag;
          r_bmag <= w_bmag;
          r_nega <= sign & a[DW-1];
          r_negb <= sign & b[VW-1];
          r_bz   <= (b == '0);
          r_ov   <= w_ovf_in;
          r_rem  <= '0;
          r_cnt  <= '0;
        end
        S_CALC: if (!w_abort) begin
          r_rem <= w_step;
          r_quo <= {r_quo[DW-2:0], ~w_step[VW]};
          r_cnt <= r_cnt + CW'(1);
        end
        S_FIX: if (!w_abort) begin
          r_q    <= w_qfin;
          r_r    <= w_rfin;
          r_dz   <= r_bz;
          r_ovf  <= r_ov;
          r_done <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign q    = r_q;
  assign r    = r_r;
  assign dz   = r_dz;
  assign ovf  = r_ovf;
  assign busy = w_busy;
  assign done = r_done;

endmodule

// File: tb/tb_divu_seq_pipe.sv
// Bench for divu_seq_pipe: directed cases, handshake corners and
// random operands against an arithmetic reference model.
module tb_divu_seq_pipe;

  logic        clk = 1'b0;
  logic        resetn = 1'b1;
  logic        start = 1'b0;
  logic        sign = 1'b0;
  logic [31:0] a = '0;
  logic [15:0] b = '0;
`ifdef DIV_ABORT_EN
  logic        abort = 1'b0;
`endif
  logic [31:0] q;
  logic [15:0] r;
  logic        dz;
  logic        ovf;
  logic        busy;
  logic        done;

  int n_chk = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  divu_seq_pipe #(.DW(32), .VW(16)) dut (
    .clk    (clk),
    .resetn (resetn),
    .start  (start),
    .sign   (sign),
    .a      (a),
    .b      (b),
`ifdef DIV_ABORT_EN
    .abort  (abort),
`endif
    .q      (q),
    .r      (r),
    .dz     (dz),
    .ovf    (ovf),
    .busy   (busy),
    .done   (done)
  );

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic void model(input bit s, input logic [31:0] aa,
                                input logic [15:0] bb,
                                output logic [31:0] eq,
                                output logic [15:0] er,
                                output bit edz, output bit eovf);
    longint sa, sb;
    edz = 0;
    eovf = 0;
    if (bb == 0) begin
      eq = 32'hFFFF_FFFF;
      er = aa[15:0];
      edz = 1;
    end else if (s && aa == 32'h8000_0000 && bb == 16'hFFFF) begin
      eq = 32'h8000_0000;
      er = 16'h0;
      eovf = 1;
    end else if (!s) begin
      eq = aa / {16'h0, bb};
      er = 16'(aa % {16'h0, bb});
    end else begin
      sa = longint'($signed(aa));
      sb = longint'($signed(bb));
      eq = 32'(sa / sb);
      er = 16'(sa % sb);
    end
  endfunction

  // Issue on a falling edge; returns one cycle later with inputs scrambled.
  task automatic drive(input bit s, input logic [31:0] aa,
                       input logic [15:0] bb);
    start = 1'b1;
    sign = s;
    a = aa;
    b = bb;
    @(negedge clk);
    start = 1'b0;
    a = $urandom;
    b = 16'($urandom);
    sign = 1'($urandom);
  endtask

  task automatic wait_done(input int lat0, output int lat,
                           output int bcnt);
    lat = lat0;
    bcnt = busy ? 1 : 0;
    while (!done && lat < 100) begin
      @(negedge clk);
      lat++;
      if (busy) bcnt++;
    end
    if (!done) chk("done_timeout", 0, 1);
  endtask

  task automatic op(input string tag, input bit s, input logic [31:0] aa,
                    input logic [15:0] bb, input logic [31:0] eq,
                    input logic [15:0] er, input bit edz, input bit eovf);
    int lat, bcnt;
    drive(s, aa, bb);
    wait_done(0, lat, bcnt);
    chk({tag, "_lat"}, lat, 33);
    chk({tag, "_busy"}, bcnt, 33);
    chk({tag, "_q"}, q, eq);
    chk({tag, "_r"}, r, er);
    chk({tag, "_dz"}, dz, edz);
    chk({tag, "_ovf"}, ovf, eovf);
  endtask

  initial begin
    int lat, bcnt, ndone;
    logic [31:0] eq;
    logic [15:0] er;
    bit edz, eovf, s;
    logic [31:0] aa;
    logic [15:0] bb;

    repeat (2) @(negedge clk);
    chk("rst_q", q, 0);
    chk("rst_r", r, 0);
    chk("rst_dz", dz, 0);
    chk("rst_ovf", ovf, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    resetn = 1'b0;
    @(negedge clk);

    op("u1000_7", 0, 32'd1000, 16'd7, 32'd142, 16'd6, 0, 0);
    op("sn1000_7", 1, 32'hFFFF_FC18, 16'd7, 32'hFFFF_FF72, 16'hFFFA, 0, 0);
    op("s1000_n7", 1, 32'd1000, 16'hFFF9, 32'hFFFF_FF72, 16'd6, 0, 0);
    op("dz", 0, 32'h1234_5678, 16'h0, 32'hFFFF_FFFF, 16'h5678, 1, 0);
    op("ovf", 1, 32'h8000_0000, 16'hFFFF, 32'h8000_0000, 16'h0, 0, 1);
    op("umax", 0, 32'hFFFF_FFFF, 16'hFFFF, 32'h0001_0001, 16'h0, 0, 0);

    drive(0, 32'd1000, 16'd7);
    repeat (4) @(negedge clk);
    start = 1'b1;
    a = 32'd50;
    b = 16'd3;
    @(negedge clk);
    start = 1'b0;
    wait_done(5, lat, bcnt);
    chk("ign_lat", lat, 33);
    chk("ign_q", q, 142);
    chk("ign_r", r, 6);

    drive(1, 32'hFFFF_FC18, 16'd7);
    chk("b2b_hold_q", q, 142);
    chk("b2b_nodone", done, 0);
    chk("b2b_busy", busy, 1);
    wait_done(0, lat, bcnt);
    chk("b2b_lat", lat, 33);
    chk("b2b_q", q, 32'hFFFF_FF72);
    chk("b2b_r", r, 16'hFFFA);

`ifdef DIV_ABORT_EN
    drive(0, 32'd77, 16'd5);
    repeat (9) @(negedge clk);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    chk("abt_busy", busy, 0);
    chk("abt_q", q, 32'hFFFF_FF72);
    chk("abt_r", r, 16'hFFFA);
    ndone = 0;
    repeat (40) begin
      @(negedge clk);
      if (done) ndone++;
    end
    chk("abt_nodone", ndone, 0);
    abort = 1'b1;
    drive(0, 32'd9, 16'd2);
    abort = 1'b0;
    chk("abt_start_wins", busy, 1);
    wait_done(0, lat, bcnt);
    chk("abt_sw_q", q, 4);
`endif

    drive(0, 32'd999, 16'd10);
    repeat (9) @(negedge clk);
    resetn = 1'b1;
    @(negedge clk);
    resetn = 1'b0;
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_q", q, 0);
    chk("mid_rst_r", r, 0);
    chk("mid_rst_done", done, 0);
    ndone = 0;
    repeat (40) begin
      @(negedge clk);
      if (done) ndone++;
    end
    chk("mid_rst_nodone", ndone, 0);

    for (int i = 0; i < 60; i++) begin
      s = 1'($urandom);
      aa = $urandom;
      bb = 16'($urandom);
      case ($urandom_range(0, 9))
        0: bb = 16'h0;
        1: begin aa = 32'h8000_0000; bb = 16'hFFFF; end
        2: bb = 16'($urandom_range(1, 15));
        3: bb = 16'h8000;
        4: aa = 32'($urandom_range(0, 20));
        default: ;
      endcase
      model(s, aa, bb, eq, er, edz, eovf);
      op($sformatf("rnd%0d", i), s, aa, bb, eq, er, edz, eovf);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
